alu_op_sequencer: RTL and testbench

//   Control-step sequencer for the CPU datapath: per instruction, runs fetch (T0-T2) and

---
 rtl/cpu_ctrl_pkg.sv | 32 +++
 rtl/reg_sel_decoder.sv | 19 +
 rtl/alu_op_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control-step sequencer: state encoding,
// opcode constants and instruction-register field placement.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_TW   = 4'd3,
        ST_T2   = 4'd4,
        ST_T3   = 4'd5,
        ST_T4   = 4'd6,
        ST_T5   = 4'd7,
        ST_T6   = 4'd8,
        ST_DONE = 4'd9
    } state_t;

    localparam int IR_W        = 32;
    localparam int DEF_NREGS   = 16;
    localparam int DEF_OP_W    = 5;
    localparam int DEF_NUM_OPS = 16;

    localparam logic [4:0] OP_AND = 5'h02;
    localparam logic [4:0] OP_MUL = 5'h0E;
    localparam logic [4:0] OP_DIV = 5'h0F;

    // Fields pack downward from the opcode: idx 0 = ra, 1 = rb, 2 = rc.
    function automatic int field_lsb(input int op_w, input int reg_w, input int idx);
        return IR_W - op_w - (idx + 1) * reg_w;
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Register index + enable to one-hot select; shared by the load (Rin) and
// drive (Rout) paths so both obey the same at-most-one-bit rule.
module reg_sel_decoder #(
    parameter int NREGS = 16,
    parameter int REG_W = $clog2(NREGS)
) (
    input  logic [REG_W-1:0] idx_i,
    input  logic             en_i,
    output logic [NREGS-1:0] sel_o
);

    always_comb begin
        sel_o = '0;
        if (en_i) begin
            sel_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control-step sequencer: fetch (T0-T2, with memory wait states) followed by
// register-register ALU execute (T3-T6); all strobes decode the state register.
module alu_op_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int              NREGS   = DEF_NREGS,
    parameter int              OP_W    = DEF_OP_W,
    parameter int              NUM_OPS = DEF_NUM_OPS,
    parameter logic [OP_W-1:0] MUL_OP  = OP_W'(OP_MUL),
    parameter logic [OP_W-1:0] DIV_OP  = OP_W'(OP_DIV)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             mem_ready,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             IncPC,
    output logic             PCin,
    output logic             MARin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             HIin,
    output logic             LOin,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic [OP_W-1:0]  alu_op,
    output logic             busy,
    output logic             done,
    output logic             err,
    output state_t           dbg_state_o
);

    localparam int REG_W  = $clog2(NREGS);
    localparam int RA_LSB = field_lsb(OP_W, REG_W, 0);
    localparam int RB_LSB = field_lsb(OP_W, REG_W, 1);
    localparam int RC_LSB = field_lsb(OP_W, REG_W, 2);

    state_t     state_q;
    logic       err_q;

    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] ra, rb, rc;
    logic             illegal;
    logic             wide;
    logic             unused_ir_bits;

    assign opcode         = ir[31 -: OP_W];
    assign ra             = ir[RA_LSB +: REG_W];
    assign rb             = ir[RB_LSB +: REG_W];
    assign rc             = ir[RC_LSB +: REG_W];
    assign unused_ir_bits = ^ir[RC_LSB-1:0];
    assign illegal        = 32'(opcode) >= 32'(NUM_OPS);
    assign wide           = (opcode == MUL_OP) || (opcode == DIV_OP);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_T0;
                        err_q   <= 1'b0;
                    end
                end
                ST_T0:   state_q <= ST_T1;
                ST_T1:   state_q <= mem_ready ? ST_T2 : ST_TW;
                ST_TW:   if (mem_ready) state_q <= ST_T2;
                ST_T2:   state_q <= ST_T3;
                // IR became valid on the T2->T3 edge, so the opcode is judged here.
                ST_T3: begin
                    if (illegal) begin
                        state_q <= ST_DONE;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= ST_T4;
                    end
                end
                ST_T4:   state_q <= ST_T5;
                ST_T5:   state_q <= wide ? ST_T6 : ST_DONE;
                ST_T6:   state_q <= ST_DONE;
                ST_DONE: begin
                    if (start) begin
                        state_q <= ST_T0;
                        err_q   <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic             rin_en;
    logic             rout_en;
    logic [REG_W-1:0] rout_idx;

    always_comb begin
        PCout    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        alu_op   = '0;
        done     = 1'b0;
        err      = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_idx = rb;
        case (state_q)
            ST_T0: begin
                PCout = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
                MARin = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_TW: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (!illegal) begin
                    rout_en = 1'b1;
                    Yin     = 1'b1;
                end
            end
            ST_T4: begin
                rout_en  = 1'b1;
                rout_idx = rc;
                Zin      = 1'b1;
                alu_op   = opcode;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (wide) LOin = 1'b1;
                else      rin_en = 1'b1;
            end
            ST_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

    reg_sel_decoder #(.NREGS(NREGS), .REG_W(REG_W)) u_rin_dec (
        .idx_i (ra),
        .en_i  (rin_en),
        .sel_o (Rin)
    );

    reg_sel_decoder #(.NREGS(NREGS), .REG_W(REG_W)) u_rout_dec (
        .idx_i (rout_idx),
        .en_i  (rout_en),
        .sel_o (Rout)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised scoreboard bench for alu_op_sequencer: each issued instruction
// pushes a per-instruction summary; a monitor rebuilds it from the strobes.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int NREGS = 16;
    localparam int OP_W  = 5;

    // Valid/ready: an instruction is issued when start is seen in IDLE/DONE;
    // its response is the single cycle with done=1, summarised in rec_t.
    typedef struct packed {
        logic        err;
        logic [7:0]  lat;
        logic [7:0]  rd;
        logic [3:0]  yin_n;
        logic [3:0]  zin_n;
        logic [3:0]  rout_n;
        logic [3:0]  rin_n;
        logic [15:0] y_rout;
        logic [15:0] z_rout;
        logic [15:0] rin;
        logic [4:0]  alu;
        logic        lo;
        logic        hi;
        logic        ok;
    } rec_t;
    localparam int W = $bits(rec_t);

    logic clock     = 1'b0;
    logic clear     = 1'b1;
    logic start     = 1'b0;
    logic mem_ready = 1'b0;
    logic [31:0] ir = '0;

    logic PCout, IncPC, PCin, MARin, Zin, Zlowout, Zhighout;
    logic Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [NREGS-1:0] Rin, Rout;
    logic [OP_W-1:0]  alu_op;
    logic busy, done, err;
    state_t dbg_state;

    alu_op_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .busy(busy), .done(done),
        .err(err), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    logic [16:0] strobes;
    assign strobes = {PCout, IncPC, PCin, MARin, Zin, Zlowout, Zhighout, Read, MDRin,
                      MDRout, IRin, Yin, HIin, LOin, busy, done, err};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic rec_t model(input logic [4:0] op, input int ra, input int rb,
                                   input int rc, input int w);
        rec_t r;
        bit ill, wide;
        ill  = (op >= 5'd16);
        wide = (op == 5'h0E) || (op == 5'h0F);
        r    = '0;
        r.ok = 1'b1;
        r.rd = 8'(1 + w);
        if (ill) begin
            r.err   = 1'b1;
            r.lat   = 8'(5 + w);          // T0 T1 TW* T2 T3 DONE
            r.zin_n = 4'd1;
        end else begin
            r.lat    = 8'((wide ? 8 : 7) + w);
            r.yin_n  = 4'd1;
            r.zin_n  = 4'd2;
            r.rout_n = 4'd2;
            r.y_rout = 16'(1 << rb);
            r.z_rout = 16'(1 << rc);
            r.alu    = op;
            r.lo     = wide;
            r.hi     = wide;
            if (!wide) begin
                r.rin_n = 4'd1;
                r.rin   = 16'(1 << ra);
            end
        end
        return r;
    endfunction

    // ---------------- memory responder ----------------
    int w_cur  = 0;
    int rd_cnt = 0;
    always @(negedge clock) begin
        if (Read) begin
            mem_ready = (rd_cnt == w_cur);
            rd_cnt    = rd_cnt + 1;
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
            rd_cnt    = 0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    rec_t acc;
    rec_t got;
    rec_t want;
    initial begin
        acc    = '0;
        acc.ok = 1'b1;
    end

    always @(negedge clock) begin
        if (!clear) begin
            acc    = '0;
            acc.ok = 1'b1;
        end else if (busy) begin
            acc.lat = acc.lat + 8'd1;
            if (Read) acc.rd = acc.rd + 8'd1;
            if (Yin) begin
                acc.yin_n  = acc.yin_n + 4'd1;
                acc.y_rout = acc.y_rout | Rout;
            end
            if (Zin) begin
                acc.zin_n  = acc.zin_n + 4'd1;
                acc.z_rout = acc.z_rout | Rout;
            end
            if (Rout != '0) acc.rout_n = acc.rout_n + 4'd1;
            if (Rin != '0)  acc.rin_n  = acc.rin_n + 4'd1;
            acc.rin = acc.rin | Rin;
            acc.alu = acc.alu | alu_op;
            acc.lo  = acc.lo | LOin;
            acc.hi  = acc.hi | HIin;
            if ($countones(Rin) > 1 || $countones(Rout) > 1 || (err && !done))
                acc.ok = 1'b0;
            if (done) begin
                acc.err = err;
                got     = acc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL instr: unexpected done, got %h", got);
                end else begin
                    want = rec_t'(exp_q.pop_front());
                    if (got !== want) begin
                        bad++;
                        $display("FAIL instr: got %h want %h", got, want);
                    end
                end
                acc    = '0;
                acc.ok = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_instr(input logic [4:0] op, input int ra, input int rb, input int rc,
                             input int w, input bit hold);
        int n;
        ir    = {op, 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
        w_cur = w;
        exp_q.push_back(W'(model(op, ra, rb, rc, w)));
        start = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) start = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < 200);
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done in %0d cycles, want done", n);
            start = 1'b0;
            clear = 1'b0;
            @(negedge clock);
            #1 clear = 1'b1;
            exp_q.delete();
        end
    endtask

    task automatic idle_gap(input int k);
        start = 1'b0;
        repeat (k) @(negedge clock);
    endtask

    initial begin
        #2 clear = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_strobes", 64'(strobes), 64'd0);
        check("reset_rin_rout", 64'({Rin, Rout}), 64'd0);
        check("reset_alu_op", 64'(alu_op), 64'd0);
        #1 clear = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_no_start", 64'(busy), 64'd0);

        // Directed cases
        run_instr(OP_AND, 1, 2, 3, 0, 1'b0);
        idle_gap(2);
        run_instr(OP_AND, 1, 2, 3, 3, 1'b0);
        idle_gap(1);
        run_instr(OP_MUL, 4, 5, 6, 0, 1'b0);
        idle_gap(1);
        run_instr(OP_DIV, 7, 7, 7, 1, 1'b0);
        idle_gap(1);
        run_instr(5'h1F, 1, 2, 3, 0, 1'b0);
        idle_gap(1);
        run_instr(OP_AND, 0, 15, 15, 0, 1'b1);
        run_instr(OP_AND, 15, 0, 0, 0, 1'b0);
        idle_gap(2);

        // Clear asserted during T4
        ir    = {OP_AND, 4'd1, 4'd2, 4'd3, 15'd0};
        w_cur = 0;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("t4_alu_op", 64'(alu_op), 64'(OP_AND));
        check("t4_rout", 64'(Rout), 64'h8);
        clear = 1'b0;
        #1;
        check("clear_strobes", 64'(strobes), 64'd0);
        check("clear_rin_rout", 64'({Rin, Rout}), 64'd0);
        check("clear_alu_op", 64'(alu_op), 64'd0);
        @(negedge clock);
        #1 clear = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("idle_after_clear", 64'(busy), 64'd0);
        end

        // Random instruction stream
        for (int i = 0; i < 150; i++) begin
            logic [4:0] op;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 2)      op = 5'($urandom_range(16, 31));
            else if (sel < 4) op = ($urandom_range(0, 1) != 0) ? OP_MUL : OP_DIV;
            else              op = 5'($urandom_range(0, 15));
            run_instr(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                      $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
        end
        idle_gap(4);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("final_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
